// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM over a shared req/ready memory port
// Registered control outputs; ir_write and the store pc_write follow mem_ready in the same cycle.
module multicycle_control_unit #(
  parameter int SUPPORT_M      = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] inst,
  input  logic       funct7_0,
  input  logic       mem_ready,
  input  logic       mdu_done,
  output logic       mem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mdu_start,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic [1:0] branch,
  output logic [1:0] reg_src,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          st;
  logic [6:0]      opcode;
  logic            m_op;
  logic            wb_pc;
  logic [TO_W-1:0] to_cnt;

  logic       d_legal, d_r, d_m, d_as, d_m2r;
  logic [1:0] d_aop, d_br, d_rs;
  logic       is_load, is_store, is_branch, timeout;

  // Decode of the live instruction bits; only consumed in DECODE.
  always_comb begin
    d_legal = (inst[1:0] == 2'b11);
    d_r     = 1'b0;
    d_as    = 1'b0;
    d_m2r   = 1'b0;
    d_aop   = 2'b00;
    d_br    = 2'b00;
    d_rs    = 2'b00;
    case (inst[6:2])
      5'b01100: begin d_aop = 2'b10; d_r = 1'b1; end
      5'b00100: begin d_aop = 2'b10; d_as = 1'b1; end
      5'b00000: begin d_as = 1'b1; d_m2r = 1'b1; end
      5'b01000: d_as = 1'b1;
      5'b11000: begin d_aop = 2'b01; d_br = 2'b10; end
      5'b11001: begin d_as = 1'b1; d_br = 2'b01; d_rs = 2'b01; end
      5'b11011: begin d_br = 2'b11; d_rs = 2'b01; end
      5'b01101: begin d_aop = 2'b11; d_as = 1'b1; end
      5'b00101: d_rs = 2'b10;
      default:  d_legal = 1'b0;
    endcase
    d_m = d_r && funct7_0;
    if (d_m && SUPPORT_M == 0) d_legal = 1'b0;
  end

  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign timeout   = mem_req && !mem_ready && (to_cnt == TO_LAST);

  assign ir_write = (st == S_FETCH) && mem_req && mem_ready;
  assign pc_write = wb_pc || ((st == S_MEM) && mem_write && mem_ready);
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_FETCH;
      opcode     <= 7'd0;
      m_op       <= 1'b0;
      wb_pc      <= 1'b0;
      to_cnt     <= '0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mdu_start  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src    <= 1'b0;
      alu_op     <= 2'b00;
      branch     <= 2'b00;
      reg_src    <= 2'b00;
    end else begin
      mdu_start <= 1'b0;
      wb_pc     <= 1'b0;
      reg_write <= 1'b0;
      if (timeout || st == S_TRAP || (st != S_FETCH && st != S_DECODE && st != S_EXEC &&
                                      st != S_MEM && st != S_WB)) begin
        st         <= S_TRAP;
        fault      <= 1'b1;
        mem_req    <= 1'b0;
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        mem_to_reg <= 1'b0;
        alu_src    <= 1'b0;
        alu_op     <= 2'b00;
        branch     <= 2'b00;
        reg_src    <= 2'b00;
      end else begin
        case (st)
          S_FETCH: begin
            // mem_req is low only on the first cycle after reset
            if (!mem_req) begin
              mem_req <= 1'b1;
            end else if (mem_ready) begin
              mem_req <= 1'b0;
              st      <= S_DECODE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_DECODE: begin
            opcode <= inst;
            if (!d_legal) begin
              st    <= S_TRAP;
              fault <= 1'b1;
            end else begin
              st         <= S_EXEC;
              m_op       <= d_m;
              mdu_start  <= d_m;
              mem_to_reg <= d_m2r;
              alu_src    <= d_as;
              alu_op     <= d_aop;
              branch     <= d_br;
              reg_src    <= d_rs;
            end
          end
          S_EXEC: begin
            if (!m_op || mdu_done) begin
              if (is_load || is_store) begin
                st        <= S_MEM;
                mem_req   <= 1'b1;
                mem_read  <= is_load;
                mem_write <= is_store;
                to_cnt    <= '0;
              end else begin
                st        <= S_WB;
                reg_write <= !is_branch;
                wb_pc     <= 1'b1;
              end
            end
          end
          S_MEM: begin
            if (mem_ready) begin
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
              if (is_store) begin
                st         <= S_FETCH;
                to_cnt     <= '0;
                m_op       <= 1'b0;
                mem_to_reg <= 1'b0;
                alu_src    <= 1'b0;
                alu_op     <= 2'b00;
                branch     <= 2'b00;
                reg_src    <= 2'b00;
              end else begin
                mem_req   <= 1'b0;
                st        <= S_WB;
                reg_write <= 1'b1;
                wb_pc     <= 1'b1;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            st         <= S_FETCH;
            mem_req    <= 1'b1;
            to_cnt     <= '0;
            m_op       <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= 2'b00;
            branch     <= 2'b00;
            reg_src    <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule
